// File: rtl/dlx_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dlx_fetch_pkg
// Description : Shared types and constants for the DLX instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package dlx_fetch_pkg;

    localparam int c_instr_w  = 32;
    localparam int c_dlx_xlen = 32;

    // IDLE: nothing outstanding, WAIT: live fetch outstanding, DROP: stale fetch outstanding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    // Buffered fetch result at the default address width; the FIFO stores it packed instr-high
    typedef struct packed {
        logic [c_instr_w-1:0]  instr;
        logic [c_dlx_xlen-1:0] npc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/dlx_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : dlx_fetch_unit_if
// Description : Instruction-memory req/gnt/rvalid bus plus IF/ID valid/ready
//               handshake; master = fetch unit, slave = memory/decode side.
// Revision    : 1.0 - initial release
// ============================================================================
interface dlx_fetch_unit_if
    import dlx_fetch_pkg::*;
#(
    parameter int XLEN = 32
) ();

    logic                 imem_req;
    logic [XLEN-1:0]      imem_addr;
    logic                 imem_gnt;
    logic                 imem_rvalid;
    logic [c_instr_w-1:0] imem_rdata;
    logic                 if_valid;
    logic                 id_ready;
    logic [c_instr_w-1:0] irout1;
    logic [XLEN-1:0]      npcout1;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output if_valid, irout1, npcout1,
        input  id_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  if_valid, irout1, npcout1,
        output id_ready
    );

endinterface
`default_nettype wire

// File: rtl/dlx_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dlx_fetch_fifo
// Description : Synchronous power-of-two FIFO with push/pop/flush; flush wins
//               over push and pop, head reads as zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module dlx_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wire logic             clock1,
    input  wire logic             reset1,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic             i_flush,
    input  wire logic [WIDTH-1:0] i_wdata,
    output logic      [CNT_W-1:0] o_count,
    output logic      [WIDTH-1:0] o_head,
    output logic                  o_valid
);

    localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop & (r_count != '0);
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign w_do_push = i_push & ((r_count != c_full) | w_do_pop);

    always_ff @(posedge clock1 or posedge reset1) begin
        if (reset1) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clock1) begin
        if (w_do_push & ~i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: rtl/dlx_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : dlx_fetch_unit
// Description : Stallable DLX fetch stage: PC, one-outstanding imem fetch,
//               NPC-tagged FIFO to decode, branch redirect with stale drop.
//               Define DLX_FETCH_PERF_EN for fetch_cnt/flush_cnt outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module dlx_fetch_unit
    import dlx_fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              PC_STEP   = 4,
    parameter int              BUF_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              FETCH_DIV = 1
) (
    input  wire logic            clock1,
    input  wire logic            reset1,
    input  wire logic            branch_en,
    input  wire logic [XLEN-1:0] alu_branch_in,
    dlx_fetch_unit_if.master     bus
`ifdef DLX_FETCH_PERF_EN
    ,
    output logic      [31:0]     fetch_cnt,
    output logic      [31:0]     flush_cnt
`endif
);

    localparam int               c_cnt_w   = $clog2(BUF_DEPTH) + 1;
    localparam int               c_entry_w = c_instr_w + XLEN;
    localparam logic [c_cnt_w:0] c_depth   = (c_cnt_w + 1)'(BUF_DEPTH);
    localparam logic [XLEN-1:0]  c_step    = XLEN'(PC_STEP);

    fetch_state_e         r_state;
    fetch_state_e         w_state_nxt;
    logic [XLEN-1:0]      r_pc;
    logic [XLEN-1:0]      r_tag_npc;
    logic [XLEN-1:0]      w_pc_inc;
    logic                 w_strobe;
    logic                 w_space;
    logic                 w_req;
    logic                 w_grant;
    logic                 w_push;
    logic                 w_pop;
    logic [c_cnt_w-1:0]   w_count;
    logic [c_cnt_w:0]     w_inflight;
    logic [c_entry_w-1:0] w_head;
    logic                 w_valid;

    generate
        if (FETCH_DIV > 1) begin : g_div
            localparam int               c_div_w    = $clog2(FETCH_DIV);
            localparam logic [c_div_w-1:0] c_div_last = c_div_w'(FETCH_DIV - 1);
            logic [c_div_w-1:0] r_divcnt;

            always_ff @(posedge clock1 or posedge reset1) begin
                if (reset1)                       r_divcnt <= '0;
                else if (r_divcnt == c_div_last)  r_divcnt <= '0;
                else                              r_divcnt <= r_divcnt + 1'b1;
            end

            assign w_strobe = (r_divcnt == c_div_last);
        end else begin : g_nodiv
            assign w_strobe = 1'b1;
        end
    endgenerate

    // The outstanding fetch reserves a slot so its word always has room on return
    assign w_inflight = {1'b0, w_count} + (c_cnt_w + 1)'(r_state != IDLE);
    assign w_space    = (w_inflight < c_depth);
    assign w_pc_inc   = r_pc + c_step;

    assign w_req   = ~reset1 & w_strobe & w_space & ~branch_en &
                     ((r_state == IDLE) | ((r_state == WAIT) & bus.imem_rvalid));
    assign w_grant = w_req & bus.imem_gnt;
    assign w_push  = ~branch_en & (r_state == WAIT) & bus.imem_rvalid;
    assign w_pop   = w_valid & bus.id_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (branch_en)             w_state_nxt = bus.imem_rvalid ? IDLE : DROP;
                else if (bus.imem_rvalid)  w_state_nxt = w_grant ? WAIT : IDLE;
            end
            DROP: begin
                if (bus.imem_rvalid) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock1 or posedge reset1) begin
        if (reset1) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clock1 or posedge reset1) begin
        if (reset1) begin
            r_pc      <= RESET_PC;
            r_tag_npc <= '0;
        end else if (branch_en) begin
            r_pc <= alu_branch_in;
        end else if (w_grant) begin
            r_pc      <= w_pc_inc;
            r_tag_npc <= w_pc_inc;
        end
    end

    dlx_fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (c_entry_w)
    ) u_fifo (
        .clock1  (clock1),
        .reset1  (reset1),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (branch_en),
        .i_wdata ({bus.imem_rdata, r_tag_npc}),
        .o_count (w_count),
        .o_head  (w_head),
        .o_valid (w_valid)
    );

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_pc;
    assign bus.if_valid  = w_valid;
    assign bus.irout1    = w_head[c_entry_w-1 -: c_instr_w];
    assign bus.npcout1   = w_head[XLEN-1:0];

`ifdef DLX_FETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clock1 or posedge reset1) begin
        if (reset1) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_push)    r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (branch_en) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire
